// File: rtl/pio_sm_scheduler.sv
// PIO state-machine scheduler: per-SM run FSM, 16.8 fractional clock
// divider tick generation and registered restart strobes.
module pio_sm_scheduler #(
  parameter int NUM_SM = 4,
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SM-1:0]       sm_enable,
  input  logic [NUM_SM-1:0]       sm_restart,
  input  logic [NUM_SM-1:0]       clkdiv_restart,
  input  logic [NUM_SM-1:0]       clkdiv_wr,
  input  logic [INT_W+FRAC_W-1:0] clkdiv_data,
  output logic [NUM_SM-1:0]       sm_tick,
  output logic [NUM_SM-1:0]       sm_restart_out,
  output logic [NUM_SM-1:0]       sm_running
);

  localparam int DW = INT_W + FRAC_W;

  typedef enum logic {
    OFF = 1'b0,
    RUN = 1'b1
  } state_t;

  localparam logic [DW-1:0] DIV_RST =
    {{(INT_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};

  for (genvar i = 0; i < NUM_SM; i++) begin : g_sm
    state_t            st_q, st_d;
    logic              rso_q, rso_d;
    logic [INT_W:0]    cnt_q, cnt_d;
    logic [FRAC_W-1:0] facc_q, facc_d;
    logic [DW-1:0]     div_q, div_d;
    logic [DW-1:0]     pend_q, pend_d;
    logic              pv_q, pv_d;
    logic [DW-1:0]     eff;
    logic [INT_W:0]    int_eff;
    logic [FRAC_W:0]   sum;
    logic              run, reload;

    assign run    = (st_q == RUN);
    assign reload = run & (cnt_q == '0);
    // A pending divisor takes over at the reload that starts the next period.
    assign eff    = pv_q ? pend_q : div_q;
    assign int_eff = (eff[DW-1:FRAC_W] == '0) ?
                     {1'b1, {INT_W{1'b0}}} :
                     {1'b0, eff[DW-1:FRAC_W]};
    assign sum    = {1'b0, facc_q} + {1'b0, eff[FRAC_W-1:0]};

    assign sm_tick[i]        = reload & ~rso_q;
    assign sm_restart_out[i] = rso_q;
    assign sm_running[i]     = run;

    always_comb begin
      st_d   = sm_enable[i] ? RUN : OFF;
      rso_d  = sm_restart[i];
      cnt_d  = cnt_q;
      facc_d = facc_q;
      div_d  = div_q;
      pend_d = pend_q;
      pv_d   = pv_q;

      if (clkdiv_wr[i] && (!run || clkdiv_restart[i])) begin
        div_d = clkdiv_data;
        pv_d  = 1'b0;
      end else begin
        if ((reload || !run) && pv_q) begin
          div_d = pend_q;
          pv_d  = 1'b0;
        end
        if (clkdiv_wr[i]) begin
          pend_d = clkdiv_data;
          pv_d   = 1'b1;
        end
      end

      if (clkdiv_restart[i] || (!run && sm_enable[i])) begin
        cnt_d  = '0;
        facc_d = '0;
      end else if (reload) begin
        cnt_d  = int_eff + {{INT_W{1'b0}}, sum[FRAC_W]}
                 - {{INT_W{1'b0}}, 1'b1};
        facc_d = sum[FRAC_W-1:0];
      end else if (run) begin
        cnt_d = cnt_q - {{INT_W{1'b0}}, 1'b1};
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q   <= OFF;
        rso_q  <= 1'b0;
        cnt_q  <= '0;
        facc_q <= '0;
        div_q  <= DIV_RST;
        pend_q <= '0;
        pv_q   <= 1'b0;
      end else begin
        st_q   <= st_d;
        rso_q  <= rso_d;
        cnt_q  <= cnt_d;
        facc_q <= facc_d;
        div_q  <= div_d;
        pend_q <= pend_d;
        pv_q   <= pv_d;
      end
    end
  end

endmodule
